plugboard_loader: RTL and testbench

Sequential configuration writer for the plugboard lookup stage. It accepts plug-pair commands over a valid/ready handshake, range-checks each command, and scans the stored pairs for conflicts. It then commits the pair into a 16-pair register file and drives the 32 `plugboard0..plugboard31` symbol buses that the forward and backward plugboard lookups read. Unused slots hold a sentinel, so the lookups fall through to identity.

---
 rtl/enigma_pkg.sv | 37 +++
 rtl/plugboard_pair_match.sv | 28 ++
 rtl/plugboard_loader.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_plugboard_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the plugboard configuration path.
//   SYMBOL_W    - width of one symbol bus
//   NUM_PAIRS   - number of plug pairs held by the loader
//   PB_SENTINEL - value driven by an empty slot; lookups treat it as "no plug"
//   cfg_op_t, resp_status_t, pb_state_t - command, status and loader FSM encodings
package enigma_pkg;

  localparam int SYMBOL_W   = 6;
  localparam int NUM_PAIRS  = 16;
  localparam int PAIR_IDX_W = 4;
  localparam logic [SYMBOL_W-1:0] PB_SENTINEL = 6'h3F;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } cfg_op_t;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_ERR_RANGE    = 3'd1,
    ST_ERR_DUP      = 3'd2,
    ST_ERR_FULL     = 3'd3,
    ST_ERR_NOTFOUND = 3'd4,
    ST_ERR_OP       = 3'd5
  } resp_status_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_WRITE = 3'd2,
    S_CLEAR = 3'd3,
    S_RESP  = 3'd4
  } pb_state_t;

endpackage

// File: rtl/plugboard_pair_match.sv
// Combinational compare of one stored plug pair against the command symbols.
// Ports:
//   valid        - the pair slot is occupied
//   sym_x, sym_y - the two stored symbols of the pair
//   key_a        - first command symbol, always compared
//   key_b        - second command symbol, compared only when key_b_en is set
//   key_b_en     - enables the key_b compare (off for DELETE)
//   hit          - occupied pair shares a symbol with the enabled keys
import enigma_pkg::*;

module plugboard_pair_match (
  input  logic                valid,
  input  logic [SYMBOL_W-1:0] sym_x,
  input  logic [SYMBOL_W-1:0] sym_y,
  input  logic [SYMBOL_W-1:0] key_a,
  input  logic [SYMBOL_W-1:0] key_b,
  input  logic                key_b_en,
  output logic                hit
);

  logic hit_a;
  logic hit_b;

  assign hit_a = (sym_x == key_a) || (sym_y == key_a);
  assign hit_b = key_b_en && ((sym_x == key_b) || (sym_y == key_b));
  assign hit   = valid && (hit_a || hit_b);

endmodule

// File: rtl/plugboard_loader.sv
// Sequential configuration writer for the plugboard lookup stage.
// Accepts ADD / CLEAR / DELETE commands, range-checks them, scans the 16
// stored pairs for conflicts one per cycle, then commits into the pair
// register file that drives the plugboard symbol buses.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   cfg_valid/cfg_ready      - command handshake
//   cfg_op, cfg_a, cfg_b     - command opcode and symbols
//   resp_valid, resp_status  - one-cycle status pulse; status holds between pulses
//   pair_count               - number of occupied pairs (0..16)
//   plugboard0..plugboard31  - registered symbol buses, pair i on 2i / 2i+1
// Build option: define PLUGBOARD_DELETE_EN to enable DELETE; otherwise DELETE
// answers ERR_OP and the delete write path is not built.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | cfg_ready high, waiting for a command
// SCAN   | 16 cycles, compare pair[scan_idx] against latched a/b
// WRITE  | commit ADD into lowest empty slot or remove DELETE target
// CLEAR  | wipe every pair back to the sentinel
// RESP   | resp_valid high for one cycle with the latched status
import enigma_pkg::*;

module plugboard_loader #(
  parameter int MAX_SYMBOL = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_op,
  input  logic [5:0] cfg_a,
  input  logic [5:0] cfg_b,
  output logic       resp_valid,
  output logic [2:0] resp_status,
  output logic [4:0] pair_count,
  output logic [5:0] plugboard0,
  output logic [5:0] plugboard1,
  output logic [5:0] plugboard2,
  output logic [5:0] plugboard3,
  output logic [5:0] plugboard4,
  output logic [5:0] plugboard5,
  output logic [5:0] plugboard6,
  output logic [5:0] plugboard7,
  output logic [5:0] plugboard8,
  output logic [5:0] plugboard9,
  output logic [5:0] plugboard10,
  output logic [5:0] plugboard11,
  output logic [5:0] plugboard12,
  output logic [5:0] plugboard13,
  output logic [5:0] plugboard14,
  output logic [5:0] plugboard15,
  output logic [5:0] plugboard16,
  output logic [5:0] plugboard17,
  output logic [5:0] plugboard18,
  output logic [5:0] plugboard19,
  output logic [5:0] plugboard20,
  output logic [5:0] plugboard21,
  output logic [5:0] plugboard22,
  output logic [5:0] plugboard23,
  output logic [5:0] plugboard24,
  output logic [5:0] plugboard25,
  output logic [5:0] plugboard26,
  output logic [5:0] plugboard27,
  output logic [5:0] plugboard28,
  output logic [5:0] plugboard29,
  output logic [5:0] plugboard30,
  output logic [5:0] plugboard31
);

  localparam logic [SYMBOL_W-1:0]   MAX_SYM  = SYMBOL_W'(MAX_SYMBOL);
  localparam logic [PAIR_IDX_W-1:0] LAST_IDX = PAIR_IDX_W'(NUM_PAIRS - 1);

  pb_state_t    state_q, state_d;
  resp_status_t status_q, status_d;

  cfg_op_t               op_q;
  logic [SYMBOL_W-1:0]   a_q, b_q;
  logic [PAIR_IDX_W-1:0] scan_idx_q;
  logic                  match_found_q;
  logic                  empty_found_q;
  logic [PAIR_IDX_W-1:0] empty_idx_q;
`ifdef PLUGBOARD_DELETE_EN
  logic [PAIR_IDX_W-1:0] match_idx_q;
`endif

  logic [SYMBOL_W-1:0] pair_a [NUM_PAIRS];
  logic [SYMBOL_W-1:0] pair_b [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] slot_valid;
  logic [4:0]           count_q;

  // Holds cfg_ready low until the first edge after reset is released.
  logic ready_en_q;

  logic accept;
  logic add_bad;
  logic cur_valid;
  logic cur_hit;
  logic match_final;
  logic empty_final;

  assign accept    = cfg_valid && cfg_ready;
  assign add_bad   = (cfg_a > MAX_SYM) || (cfg_b > MAX_SYM) || (cfg_a == cfg_b);
  assign cur_valid = slot_valid[scan_idx_q];

  plugboard_pair_match u_pair_match (
    .valid    (cur_valid),
    .sym_x    (pair_a[scan_idx_q]),
    .sym_y    (pair_b[scan_idx_q]),
    .key_a    (a_q),
    .key_b    (b_q),
    .key_b_en (op_q == OP_ADD),
    .hit      (cur_hit)
  );

  // Verdict on the last scan cycle must include that cycle's compare.
  assign match_final = match_found_q || cur_hit;
  assign empty_final = empty_found_q || !cur_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cfg_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready = ready_en_q;
        if (accept) begin
          case (cfg_op_t'(cfg_op))
            OP_ADD: begin
              if (add_bad) begin
                state_d  = S_RESP;
                status_d = ST_ERR_RANGE;
              end else begin
                state_d = S_SCAN;
              end
            end
            OP_CLEAR: state_d = S_CLEAR;
`ifdef PLUGBOARD_DELETE_EN
            OP_DELETE: begin
              if (cfg_a > MAX_SYM) begin
                state_d  = S_RESP;
                status_d = ST_ERR_RANGE;
              end else begin
                state_d = S_SCAN;
              end
            end
`endif
            default: begin
              state_d  = S_RESP;
              status_d = ST_ERR_OP;
            end
          endcase
        end
      end
      S_SCAN: begin
        if (scan_idx_q == LAST_IDX) begin
          if (op_q == OP_ADD) begin
            if (match_final) begin
              state_d  = S_RESP;
              status_d = ST_ERR_DUP;
            end else if (!empty_final) begin
              state_d  = S_RESP;
              status_d = ST_ERR_FULL;
            end else begin
              state_d = S_WRITE;
            end
          end else begin
            if (!match_final) begin
              state_d  = S_RESP;
              status_d = ST_ERR_NOTFOUND;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        state_d  = S_RESP;
        status_d = ST_OK;
      end
      S_CLEAR: begin
        state_d  = S_RESP;
        status_d = ST_OK;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q    <= 1'b0;
      status_q      <= ST_OK;
      op_q          <= OP_ADD;
      a_q           <= '0;
      b_q           <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      empty_found_q <= 1'b0;
      empty_idx_q   <= '0;
`ifdef PLUGBOARD_DELETE_EN
      match_idx_q   <= '0;
`endif
      slot_valid    <= '0;
      count_q       <= '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
        pair_a[i] <= PB_SENTINEL;
        pair_b[i] <= PB_SENTINEL;
      end
    end else begin
      ready_en_q <= 1'b1;
      status_q   <= status_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q          <= cfg_op_t'(cfg_op);
            a_q           <= cfg_a;
            b_q           <= cfg_b;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            empty_found_q <= 1'b0;
            empty_idx_q   <= '0;
          end
        end
        S_SCAN: begin
          scan_idx_q <= scan_idx_q + 1'b1;
          if (cur_hit && !match_found_q) begin
            match_found_q <= 1'b1;
`ifdef PLUGBOARD_DELETE_EN
            match_idx_q   <= scan_idx_q;
`endif
          end
          if (!cur_valid && !empty_found_q) begin
            empty_found_q <= 1'b1;
            empty_idx_q   <= scan_idx_q;
          end
        end
        S_WRITE: begin
          if (op_q == OP_ADD) begin
            pair_a[empty_idx_q]     <= a_q;
            pair_b[empty_idx_q]     <= b_q;
            slot_valid[empty_idx_q] <= 1'b1;
            count_q                 <= count_q + 5'd1;
          end
`ifdef PLUGBOARD_DELETE_EN
          else if (op_q == OP_DELETE) begin
            pair_a[match_idx_q]     <= PB_SENTINEL;
            pair_b[match_idx_q]     <= PB_SENTINEL;
            slot_valid[match_idx_q] <= 1'b0;
            count_q                 <= count_q - 5'd1;
          end
`endif
        end
        S_CLEAR: begin
          slot_valid <= '0;
          count_q    <= '0;
          for (int i = 0; i < NUM_PAIRS; i++) begin
            pair_a[i] <= PB_SENTINEL;
            pair_b[i] <= PB_SENTINEL;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_status = status_q;
  assign pair_count  = count_q;

  assign plugboard0  = pair_a[0];
  assign plugboard1  = pair_b[0];
  assign plugboard2  = pair_a[1];
  assign plugboard3  = pair_b[1];
  assign plugboard4  = pair_a[2];
  assign plugboard5  = pair_b[2];
  assign plugboard6  = pair_a[3];
  assign plugboard7  = pair_b[3];
  assign plugboard8  = pair_a[4];
  assign plugboard9  = pair_b[4];
  assign plugboard10 = pair_a[5];
  assign plugboard11 = pair_b[5];
  assign plugboard12 = pair_a[6];
  assign plugboard13 = pair_b[6];
  assign plugboard14 = pair_a[7];
  assign plugboard15 = pair_b[7];
  assign plugboard16 = pair_a[8];
  assign plugboard17 = pair_b[8];
  assign plugboard18 = pair_a[9];
  assign plugboard19 = pair_b[9];
  assign plugboard20 = pair_a[10];
  assign plugboard21 = pair_b[10];
  assign plugboard22 = pair_a[11];
  assign plugboard23 = pair_b[11];
  assign plugboard24 = pair_a[12];
  assign plugboard25 = pair_b[12];
  assign plugboard26 = pair_a[13];
  assign plugboard27 = pair_b[13];
  assign plugboard28 = pair_a[14];
  assign plugboard29 = pair_b[14];
  assign plugboard30 = pair_a[15];
  assign plugboard31 = pair_b[15];

endmodule

// File: tb/tb_plugboard_loader.sv
// Self-checking bench for plugboard_loader: directed cases plus random
// commands, all compared against a behavioural model of the pair table.
// MAX_SYMBOL is raised to 40 so that 16 disjoint pairs can be stored.
module tb_plugboard_loader;

  localparam int TB_MAX = 40;
  localparam int SENT   = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_op;
  logic [5:0]  cfg_a;
  logic [5:0]  cfg_b;
  logic        resp_valid;
  logic [2:0]  resp_status;
  logic [4:0]  pair_count;
  logic [31:0][5:0] pb;

  int n_tests = 0;
  int n_fail  = 0;

  // model of the pair table
  int m_a [16];
  int m_b [16];
  bit m_v [16];
  int m_cnt;

  always #5 clk = ~clk;

  plugboard_loader #(.MAX_SYMBOL(TB_MAX)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .resp_valid(resp_valid), .resp_status(resp_status), .pair_count(pair_count),
    .plugboard0(pb[0]),   .plugboard1(pb[1]),   .plugboard2(pb[2]),   .plugboard3(pb[3]),
    .plugboard4(pb[4]),   .plugboard5(pb[5]),   .plugboard6(pb[6]),   .plugboard7(pb[7]),
    .plugboard8(pb[8]),   .plugboard9(pb[9]),   .plugboard10(pb[10]), .plugboard11(pb[11]),
    .plugboard12(pb[12]), .plugboard13(pb[13]), .plugboard14(pb[14]), .plugboard15(pb[15]),
    .plugboard16(pb[16]), .plugboard17(pb[17]), .plugboard18(pb[18]), .plugboard19(pb[19]),
    .plugboard20(pb[20]), .plugboard21(pb[21]), .plugboard22(pb[22]), .plugboard23(pb[23]),
    .plugboard24(pb[24]), .plugboard25(pb[25]), .plugboard26(pb[26]), .plugboard27(pb[27]),
    .plugboard28(pb[28]), .plugboard29(pb[29]), .plugboard30(pb[30]), .plugboard31(pb[31])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0;
      m_a[i] = SENT;
      m_b[i] = SENT;
    end
    m_cnt = 0;
  endfunction

  // Applies one command to the model; returns expected status and the number
  // of cycles from the accept edge to the cycle carrying resp_valid.
  function automatic void model_cmd(input int op, input int a, input int b,
                                    output int st, output int lat);
    int hit;
    int slot;
    hit  = -1;
    slot = -1;
    st   = 0;
    lat  = 1;
    if (op == 0) begin
      if (a > TB_MAX || b > TB_MAX || a == b) begin
        st = 1; lat = 1;
      end else begin
        for (int i = 0; i < 16; i++)
          if (m_v[i] && (m_a[i] == a || m_b[i] == a || m_a[i] == b || m_b[i] == b)) hit = i;
        for (int i = 15; i >= 0; i--)
          if (!m_v[i]) slot = i;
        if (hit >= 0) begin
          st = 2; lat = 17;
        end else if (slot < 0) begin
          st = 3; lat = 17;
        end else begin
          m_v[slot] = 1'b1; m_a[slot] = a; m_b[slot] = b; m_cnt++;
          st = 0; lat = 18;
        end
      end
    end else if (op == 1) begin
      model_reset();
      st = 0; lat = 2;
    end else if (op == 2) begin
`ifdef PLUGBOARD_DELETE_EN
      if (a > TB_MAX) begin
        st = 1; lat = 1;
      end else begin
        for (int i = 15; i >= 0; i--)
          if (m_v[i] && (m_a[i] == a || m_b[i] == a)) hit = i;
        if (hit < 0) begin
          st = 4; lat = 17;
        end else begin
          m_v[hit] = 1'b0; m_a[hit] = SENT; m_b[hit] = SENT; m_cnt--;
          st = 0; lat = 18;
        end
      end
`else
      st = 5; lat = 1;
`endif
    end else begin
      st = 5; lat = 1;
    end
  endfunction

  task automatic check_table(input string tag);
    check({tag, " pair_count"}, int'(pair_count), m_cnt);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s pb%0d", tag, 2*i),   int'(pb[2*i]),   m_v[i] ? m_a[i] : SENT);
      check($sformatf("%s pb%0d", tag, 2*i+1), int'(pb[2*i+1]), m_v[i] ? m_b[i] : SENT);
    end
  endtask

  // Issues one command from a negedge and checks response timing, status and table.
  task automatic do_cmd(input int op, input int a, input int b, input string tag);
    int st, lat, waited, got_lat;
    bit seen;
    waited = 0;
    while (!cfg_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) begin
      check({tag, " ready_timeout"}, 0, 1);
      return;
    end
    model_cmd(op, a, b, st, lat);
    cfg_valid = 1'b1;
    cfg_op    = 2'(op);
    cfg_a     = 6'(a);
    cfg_b     = 6'(b);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    seen    = 1'b0;
    got_lat = 0;
    while (!seen && got_lat < 40) begin
      @(negedge clk);
      got_lat++;
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, " resp_timeout"}, 0, 1);
      return;
    end
    check({tag, " latency"}, got_lat, lat);
    check({tag, " status"}, int'(resp_status), st);
    check({tag, " ready_in_resp"}, int'(cfg_ready), 0);
    check_table(tag);
    @(negedge clk);
    check({tag, " resp_pulse_end"}, int'(resp_valid), 0);
    check({tag, " status_hold"}, int'(resp_status), st);
    check({tag, " ready_after"}, int'(cfg_ready), 1);
  endtask

  initial begin
    int op, r, a, b;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_op    = 2'd0;
    cfg_a     = 6'd0;
    cfg_b     = 6'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst cfg_ready", int'(cfg_ready), 0);
    check("rst resp_valid", int'(resp_valid), 0);
    check("rst resp_status", int'(resp_status), 0);
    check_table("rst");
    rst = 1'b0;
    #1;
    check("release ready_before_edge", int'(cfg_ready), 0);
    @(negedge clk);
    check("release ready_after_edge", int'(cfg_ready), 1);

    do_cmd(0, 0, 4, "add_0_4");
    do_cmd(0, 4, 9, "add_dup");
    do_cmd(0, 7, 7, "add_same");
    do_cmd(0, 3, TB_MAX + 1, "add_range");
    do_cmd(0, TB_MAX, 1, "add_max_legal");
    do_cmd(2, 4, 0, "del_4");
    do_cmd(0, 5, 6, "add_5_6");
    do_cmd(2, 20, 0, "del_absent");
    do_cmd(2, TB_MAX + 1, 0, "del_range");
    do_cmd(3, 1, 2, "op_rsvd");
    do_cmd(0, 10, 11, "add_10_11");
    do_cmd(0, 12, 13, "add_12_13");
    do_cmd(0, 14, 15, "add_14_15");
    do_cmd(1, 0, 0, "clear");

    // 16 disjoint pairs that avoid symbols 24 and 25
    for (int k = 0; k < 16; k++) begin
      a = (2*k < 24)   ? 2*k   : 2*k + 2;
      b = (2*k+1 < 24) ? 2*k+1 : 2*k + 3;
      do_cmd(0, a, b, $sformatf("fill%0d", k));
    end
    do_cmd(0, 24, 25, "add_full");

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 19);
      op = (r < 11) ? 0 : (r < 16) ? 2 : (r < 18) ? 1 : 3;
      a  = $urandom_range(0, TB_MAX + 2);
      b  = $urandom_range(0, TB_MAX + 2);
      do_cmd(op, a, b, $sformatf("rnd%0d", n));
    end

    // reset while an ADD is in its eighth scan cycle
    if (m_cnt == 0) do_cmd(0, 1, 2, "pre_abort_add");
    cfg_valid = 1'b1;
    cfg_op    = 2'd0;
    cfg_a     = 6'd38;
    cfg_b     = 6'd39;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("abort resp_valid", int'(resp_valid), 0);
    check("abort cfg_ready", int'(cfg_ready), 0);
    check_table("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort hold%0d resp_valid", k), int'(resp_valid), 0);
    end
    rst = 1'b0;
    #1;
    check("abort ready_before_edge", int'(cfg_ready), 0);
    @(negedge clk);
    check("abort ready_after_edge", int'(cfg_ready), 1);
    check_table("abort_post");
    do_cmd(0, 38, 39, "add_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
